// File: rtl/seq_shift_add_mult_if.sv
// Handshake and operand/result bundle for the iterative shift-add multiplier.
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic                 clear;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 valid;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, signed_mode, clear, a, b,
        input  busy, valid, product
    );

    modport slave (
        input  start, signed_mode, clear, a, b,
        output busy, valid, product
    );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative MSB-first shift-add multiplier with start/busy/valid handshake,
// held result register and optional sign-magnitude signed mode.
module seq_shift_add_mult #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_shift_add_mult_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] ma_q, ma_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic             neg_q, neg_d;
    logic             valid_q, valid_d;

    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    addend;

    // Magnitude of the most negative value wraps back onto itself, which is
    // exactly its unsigned magnitude.
    assign signed_op = SIGNED_EN && bus.signed_mode;
    assign a_neg     = signed_op && bus.a[WIDTH-1];
    assign b_neg     = signed_op && bus.b[WIDTH-1];
    assign a_mag     = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_mag     = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
    assign addend    = mb_q[count_q] ? {{WIDTH{1'b0}}, ma_q} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            product_q <= '0;
            count_q   <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            neg_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            count_q   <= count_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            neg_q     <= neg_d;
            valid_q   <= valid_d;
        end
    end

    // The valid cycle already sits in IDLE but still counts as busy, so a
    // start seen alongside valid_q is dropped.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        product_d = product_q;
        count_d   = count_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        neg_d     = neg_q;
        valid_d   = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !valid_q) begin
                        ma_d    = a_mag;
                        mb_d    = b_mag;
                        neg_d   = a_neg ^ b_neg;
                        acc_d   = '0;
                        count_d = CW'(WIDTH - 1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d = {acc_q[PW-2:0], 1'b0} + addend;
                    if (count_q == '0) begin
                        state_d = FIN;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
                FIN: begin
                    product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy    = (state_q != IDLE) || valid_q;
        bus.valid   = valid_q;
        bus.product = product_q;
    end
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench: a signed-enabled and an unsigned-only instance driven in
// lockstep, each checked against hand-computed products.
module tb_seq_shift_add_mult;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;

    seq_shift_add_mult_if #(.WIDTH(8)) s_if ();
    seq_shift_add_mult_if #(.WIDTH(8)) u_if ();

    seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic st, input logic sm, input logic cl,
                                 input logic [7:0] av, input logic [7:0] bv);
        s_if.start = st; s_if.signed_mode = sm; s_if.clear = cl; s_if.a = av; s_if.b = bv;
        u_if.start = st; u_if.signed_mode = sm; u_if.clear = cl; u_if.a = av; u_if.b = bv;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; valid must land 9 edges after the start edge
    // with busy high for 10 sampled cycles.
    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input logic [15:0] exp_s, input logic [15:0] exp_u);
        int n;
        int busy_cycles;
        applyStimulus(1'b1, sm, 1'b0, av, bv);
        tick();
        applyStimulus(1'b0, ~sm, 1'b0, 8'hAA, 8'h55);
        n = 0;
        busy_cycles = s_if.busy ? 1 : 0;
        while (!s_if.valid && n < 30) begin
            tick();
            n++;
            if (s_if.busy) busy_cycles++;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'd9);
        checkOutput({tag, " busy_cycles"}, 32'(busy_cycles), 32'd10);
        checkOutput({tag, " s_product"}, 32'(s_if.product), 32'(exp_s));
        checkOutput({tag, " u_valid"}, 32'(u_if.valid), 32'd1);
        checkOutput({tag, " u_product"}, 32'(u_if.product), 32'(exp_u));
        tick();
        checkOutput({tag, " valid_drop"}, 32'(s_if.valid), 32'd0);
        checkOutput({tag, " busy_drop"}, 32'(s_if.busy), 32'd0);
        checkOutput({tag, " s_hold"}, 32'(s_if.product), 32'(exp_s));
    endtask

    initial begin
        int seen;
        logic exp_valid;
        logic [15:0] exp_prod;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        checkOutput("reset busy", 32'(s_if.busy), 32'd0);
        checkOutput("reset valid", 32'(s_if.valid), 32'd0);
        checkOutput("reset product", 32'(s_if.product), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        runOp("3x8", 8'd3, 8'd8, 1'b0, 16'h0018, 16'h0018);
        runOp("FFxFF_u", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01);
        runOp("FFxFF_s", 8'hFF, 8'hFF, 1'b1, 16'h0001, 16'hFE01);
        runOp("FDx05_s", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 16'h04F1);
        runOp("80x80_s", 8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000);
        runOp("80x7F_s", 8'h80, 8'h7F, 1'b1, 16'hC080, 16'h3F80);
        runOp("0x85_s", 8'h00, 8'h85, 1'b1, 16'h0000, 16'h0000);

        // Start held high: accepts at edges 0, 11, 22 (edge 10 and 21 fall
        // in a valid cycle and are ignored).
        for (int j = 0; j <= 32; j++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'(10 + j), 8'(3 + j));
            tick();
            exp_valid = (j == 9) || (j == 20) || (j == 31);
            exp_prod  = (j == 9) ? 16'h001E : (j == 20) ? 16'h0126 : 16'h0320;
            checkOutput($sformatf("hold_start valid j=%0d", j), 32'(s_if.valid), 32'(exp_valid));
            if (exp_valid) begin
                checkOutput($sformatf("hold_start s_product j=%0d", j), 32'(s_if.product), 32'(exp_prod));
                checkOutput($sformatf("hold_start u_product j=%0d", j), 32'(u_if.product), 32'(exp_prod));
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checkOutput("hold_start idle", 32'(s_if.busy), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, 8'd6);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 8'd6);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd5, 8'd6);
        tick();
        checkOutput("clear busy", 32'(s_if.busy), 32'd0);
        checkOutput("clear valid", 32'(s_if.valid), 32'd0);
        checkOutput("clear product", 32'(s_if.product), 32'h0320);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 8'd6);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_if.valid) seen++;
        end
        checkOutput("clear no_valid", 32'(seen), 32'd0);
        checkOutput("clear hold", 32'(s_if.product), 32'h0320);

        applyStimulus(1'b1, 1'b0, 1'b1, 8'd9, 8'd9);
        tick();
        checkOutput("clear_start busy", 32'(s_if.busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_if.valid || s_if.busy) seen++;
        end
        checkOutput("clear_start no_run", 32'(seen), 32'd0);
        checkOutput("clear_start hold", 32'(s_if.product), 32'h0320);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, 8'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h11, 8'h22);
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst busy", 32'(s_if.busy), 32'd0);
        checkOutput("async_rst valid", 32'(s_if.valid), 32'd0);
        checkOutput("async_rst s_product", 32'(s_if.product), 32'd0);
        checkOutput("async_rst u_product", 32'(u_if.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst idle", 32'(s_if.busy), 32'd0);
        runOp("7x9", 8'd7, 8'd9, 1'b0, 16'h003F, 16'h003F);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
